// File: rtl/serial_audio_pkg.sv
// Shared definitions for the serial audio encoder/decoder pair.
package serial_audio_pkg;

    localparam int unsigned SLOT_W16 = 16;
    localparam int unsigned SLOT_W32 = 32;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } channel_e;

    typedef enum logic {
        FMT_LJ  = 1'b0,
        FMT_I2S = 1'b1
    } format_e;

    // Mode inputs captured at each slot start and held for the whole slot.
    typedef struct packed {
        format_e fmt;
        logic    polarity;
        logic    wide;
    } slot_cfg_t;

    // Index of the last bit in a slot of the given width.
    function automatic logic [4:0] slot_last_bit(input logic wide);
        return wide ? 5'(SLOT_W32 - 1) : 5'(SLOT_W16 - 1);
    endfunction

endpackage

// File: rtl/serial_audio_encoder_if.sv
// Sample stream handshake between a producer and the serial audio encoder.
interface serial_audio_encoder_if;

    logic        i_valid;
    logic        i_ready;
    logic        i_is_left;
    logic [31:0] i_audio;

    modport master (
        output i_valid,
        output i_is_left,
        output i_audio,
        input  i_ready
    );

    modport slave (
        input  i_valid,
        input  i_is_left,
        input  i_audio,
        output i_ready
    );

endinterface

// File: rtl/serial_audio_clock_gen.sv
// Bit clock divider: sclk toggles every SCLK_HALF master clocks; fall_o marks
// the master-clock cycle in which sclk goes from 1 to 0.
module serial_audio_clock_gen #(
    parameter int unsigned SCLK_HALF = 2
) (
    input  logic clk,
    input  logic reset,
    output logic sclk_o,
    output logic fall_o
);

    localparam int unsigned DIV_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             sclk_q, sclk_d;
    logic             term;

    // Divider next state and fall strobe.
    always_comb begin
        term   = (div_q == DIV_W'(SCLK_HALF - 1));
        div_d  = term ? '0 : div_q + 1'b1;
        sclk_d = term ? ~sclk_q : sclk_q;
        fall_o = term & sclk_q;
    end

    // Divider and sclk registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;

endmodule

// File: rtl/serial_audio_encoder.sv
// Parallel-to-serial audio transmitter producing lrclk/sclk/sdout in
// left-justified or I2S framing with 16- or 32-bit slots.
module serial_audio_encoder
    import serial_audio_pkg::*;
#(
    parameter int unsigned SCLK_HALF = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         is_i2s,
    input  logic                         lrclk_polarity,
    input  logic                         is_32bit,
    serial_audio_encoder_if.slave        samp,
    output logic                         lrclk,
    output logic                         sclk,
    output logic                         sdout,
    output logic                         is_error
);

    logic fall;

    serial_audio_clock_gen #(
        .SCLK_HALF (SCLK_HALF)
    ) u_clock_gen (
        .clk    (clk),
        .reset  (reset),
        .sclk_o (sclk),
        .fall_o (fall)
    );

    slot_cfg_t        cfg_q, cfg_d;
    channel_e         chan_q, chan_d;
    logic             lr_right_q, lr_right_d;
    logic             slotted_q, slotted_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [1:0][31:0] hold_q, hold_d;
    logic [1:0]       full_q, full_d;
    logic             started_q, started_d;
    logic             err_q, err_d;
    logic [31:0]      shift_q, shift_d;
    logic             lj_q, lj_d;
    logic             sdout_q, sdout_d;

    logic             slot_start;
    logic             load_ok;
    logic [31:0]      word;
    logic             lj_bit;
    channel_e         sel;
    logic             accept;

    // Holding registers and the input handshake.
    always_comb begin
        sel          = samp.i_is_left ? CH_LEFT : CH_RIGHT;
        samp.i_ready = ~full_q[sel];
        accept       = samp.i_valid & ~full_q[sel];
        load_ok      = full_q[chan_q];
        full_d       = full_q;
        hold_d       = hold_q;
        // Loading the current channel and accepting into it never coincide:
        // a full channel is not ready, an empty one has nothing to load.
        if (slot_start && load_ok) begin
            full_d[chan_q] = 1'b0;
        end
        if (accept) begin
            full_d[sel] = 1'b1;
            hold_d[sel] = samp.i_audio;
        end
        started_d = started_q | accept;
    end

    // Slot sequencing, shift register and serial output.
    always_comb begin
        slot_start = fall && (bit_cnt_q == slot_last_bit(cfg_q.wide));

        cfg_d = cfg_q;
        if (slot_start) begin
            cfg_d.fmt      = is_i2s ? FMT_I2S : FMT_LJ;
            cfg_d.polarity = lrclk_polarity;
            cfg_d.wide     = is_32bit;
        end

        bit_cnt_d = bit_cnt_q;
        if (fall) begin
            bit_cnt_d = slot_start ? '0 : bit_cnt_q + 5'd1;
        end

        chan_d     = chan_q;
        lr_right_d = lr_right_q;
        if (slot_start) begin
            chan_d     = (chan_q == CH_LEFT) ? CH_RIGHT : CH_LEFT;
            lr_right_d = (chan_q == CH_RIGHT);
        end
        slotted_d = slotted_q | slot_start;

        word    = load_ok ? hold_q[chan_q] : '0;
        lj_bit  = slot_start ? word[31] : shift_q[31];
        shift_d = shift_q;
        lj_d    = lj_q;
        sdout_d = sdout_q;
        if (fall) begin
            shift_d = slot_start ? (word << 1) : (shift_q << 1);
            lj_d    = lj_bit;
            // I2S sends the bit left-justified framing sent one fall earlier.
            sdout_d = (cfg_d.fmt == FMT_I2S) ? lj_q : lj_bit;
        end

        err_d = err_q | (slot_start & ~load_ok & started_q);
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_q      <= '{fmt: FMT_LJ, polarity: 1'b0, wide: 1'b0};
            chan_q     <= CH_LEFT;
            lr_right_q <= 1'b0;
            slotted_q  <= 1'b0;
            bit_cnt_q  <= '0;
            hold_q     <= '0;
            full_q     <= '0;
            started_q  <= 1'b0;
            err_q      <= 1'b0;
            shift_q    <= '0;
            lj_q       <= 1'b0;
            sdout_q    <= 1'b0;
        end else begin
            cfg_q      <= cfg_d;
            chan_q     <= chan_d;
            lr_right_q <= lr_right_d;
            slotted_q  <= slotted_d;
            bit_cnt_q  <= bit_cnt_d;
            hold_q     <= hold_d;
            full_q     <= full_d;
            started_q  <= started_d;
            err_q      <= err_d;
            shift_q    <= shift_d;
            lj_q       <= lj_d;
            sdout_q    <= sdout_d;
        end
    end

    // Until the first slot boundary lrclk rests at the live left level.
    assign lrclk    = slotted_q ? (lr_right_q ? ~cfg_q.polarity : cfg_q.polarity)
                                : lrclk_polarity;
    assign sdout    = sdout_q;
    assign is_error = err_q;

endmodule

// File: tb/tb_serial_audio_encoder.sv
// Directed bench for serial_audio_encoder: a frame-level model checked every
// cycle, plus a small receiver whose recovered words are pinned to literals.
module tb_serial_audio_encoder;

    localparam int unsigned SH = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic is_i2s = 1'b0;
    logic lrclk_polarity = 1'b0;
    logic is_32bit = 1'b0;
    logic lrclk, sclk, sdout, is_error;

    serial_audio_encoder_if bus ();

    serial_audio_encoder #(
        .SCLK_HALF (SH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .is_i2s         (is_i2s),
        .lrclk_polarity (lrclk_polarity),
        .is_32bit       (is_32bit),
        .samp           (bus),
        .lrclk          (lrclk),
        .sclk           (sclk),
        .sdout          (sdout),
        .is_error       (is_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: dut=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    int unsigned m_t;
    logic [1:0]  m_full;
    logic [31:0] m_hold [2];
    logic        m_started, m_err, m_next_right, m_slotted, m_i2s;
    logic        m_prev_lj, m_lj, m_sd, m_lr, m_acc;
    logic [31:0] m_word;
    int          m_c, m_w, m_in;
    bit          m_q_sd [$];
    bit          m_q_lr [$];

    task automatic model_reset();
        m_t = 0; m_full = '0; m_started = 0; m_err = 0; m_next_right = 0;
        m_slotted = 0; m_i2s = 0; m_prev_lj = 0; m_sd = 0; m_lr = 0;
        m_hold[0] = '0; m_hold[1] = '0;
        m_q_sd.delete(); m_q_lr.delete();
        // The power-on 16-bit slot runs out after 15 more bit times.
        for (int i = 0; i < 15; i++) begin
            m_q_sd.push_back(1'b0);
            m_q_lr.push_back(1'b0);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_reset();
        end else begin
            m_in  = bus.i_is_left ? 0 : 1;
            m_acc = bus.i_valid && !m_full[m_in];
            m_t++;
            if (m_t % (2 * SH) == 0) begin
                if (m_q_sd.size() == 0) begin
                    m_c = m_next_right ? 1 : 0;
                    m_next_right = !m_next_right;
                    m_w = is_32bit ? 32 : 16;
                    m_i2s = is_i2s;
                    if (m_full[m_c]) begin
                        m_word = m_hold[m_c];
                        m_full[m_c] = 1'b0;
                    end else begin
                        m_word = '0;
                        if (m_started) m_err = 1'b1;
                    end
                    for (int i = 0; i < m_w; i++) begin
                        m_q_sd.push_back(m_word[31 - i]);
                        m_q_lr.push_back(m_c == 0 ? lrclk_polarity : !lrclk_polarity);
                    end
                    m_slotted = 1'b1;
                end
                m_lj = m_q_sd.pop_front();
                m_lr = m_q_lr.pop_front();
                m_sd = m_i2s ? m_prev_lj : m_lj;
                m_prev_lj = m_lj;
            end
            if (m_acc) begin
                m_full[m_in] = 1'b1;
                m_hold[m_in] = bus.i_audio;
                m_started = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("sclk", 32'(sclk), 32'((m_t / SH) % 2));
        chk("lrclk", 32'(lrclk), 32'(m_slotted ? m_lr : lrclk_polarity));
        chk("sdout", 32'(sdout), 32'(m_sd));
        chk("i_ready", 32'(bus.i_ready), 32'(!m_full[bus.i_is_left ? 0 : 1]));
        chk("is_error", 32'(is_error), 32'(m_err));
    end

    // ---------------- receiver ----------------
    logic [31:0] rx_sr = '0;
    logic        rx_prev = 1'b0;
    logic [31:0] rx_words [$];
    logic        rx_left [$];

    always @(posedge sclk) begin
        if (lrclk !== rx_prev) begin
            if (is_i2s) begin
                rx_words.push_back({rx_sr[30:0], sdout});
                rx_sr = '0;
            end else begin
                rx_words.push_back(rx_sr);
                rx_sr = {31'b0, sdout};
            end
            rx_left.push_back(rx_prev == lrclk_polarity);
            rx_prev = lrclk;
        end else begin
            rx_sr = {rx_sr[30:0], sdout};
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset(input logic i2s, input logic pol, input logic w32);
        @(posedge clk); #1;
        reset = 1'b1;
        is_i2s = i2s; lrclk_polarity = pol; is_32bit = w32;
        bus.i_valid = 1'b0; bus.i_is_left = 1'b1; bus.i_audio = '0;
        @(negedge clk);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_lrclk", 32'(lrclk), 32'(pol));
        chk("rst_sdout", 32'(sdout), 32'd0);
        chk("rst_err", 32'(is_error), 32'd0);
        chk("rst_ready", 32'(bus.i_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rx_words.delete(); rx_left.delete();
        rx_sr = '0; rx_prev = pol;
        reset = 1'b0;
    endtask

    task automatic send(input logic left, input logic [31:0] d);
        int n = 0;
        bus.i_valid = 1'b1; bus.i_is_left = left; bus.i_audio = d;
        @(negedge clk);
        while (bus.i_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 2000) begin
            n_fail++;
            $display("FAIL send_timeout: ready=%b expected=1", bus.i_ready);
        end
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic wait_words(input int k);
        int n = 0;
        while (rx_words.size() < k && n < 4000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (rx_words.size() < k) begin
            n_fail++;
            $display("FAIL rx_timeout: words=%0d expected=%0d", rx_words.size(), k);
        end
    endtask

    task automatic wait_t(input int unsigned t);
        int n = 0;
        while (m_t != t && n < 4000) begin
            @(negedge clk);
            n++;
        end
    endtask

    int rises;
    logic prev_sclk, saw_one;

    initial begin
        bus.i_valid = 1'b0; bus.i_is_left = 1'b1; bus.i_audio = '0;

        // Left-justified, 16-bit.
        do_reset(1'b0, 1'b0, 1'b0);
        send(1'b1, 32'h1fed0000);
        send(1'b0, 32'h33330000);
        wait_words(1);
        chk("lj16_err", 32'(is_error), 32'd0);
        wait_words(2);
        chk("lj16_w0", rx_words[0], 32'h00001fed);
        chk("lj16_ch0", 32'(rx_left[0]), 32'd1);
        chk("lj16_w1", rx_words[1], 32'h00003333);
        chk("lj16_ch1", 32'(rx_left[1]), 32'd0);

        // I2S, 32-bit, lrclk high marks left.
        do_reset(1'b1, 1'b1, 1'b1);
        send(1'b1, 32'hAAAAAAAA);
        send(1'b0, 32'h99999999);
        wait_words(1);
        chk("i2s32_err", 32'(is_error), 32'd0);
        wait_words(2);
        chk("i2s32_w0", rx_words[0], 32'hAAAAAAAA);
        chk("i2s32_ch0", 32'(rx_left[0]), 32'd1);
        chk("i2s32_w1", rx_words[1], 32'h99999999);
        chk("i2s32_ch1", 32'(rx_left[1]), 32'd0);

        // Underflow on the right slot.
        do_reset(1'b0, 1'b0, 1'b0);
        send(1'b1, 32'h12340000);
        wait_words(2);
        chk("uf_w0", rx_words[0], 32'h00001234);
        chk("uf_w1", rx_words[1], 32'h00000000);
        chk("uf_err", 32'(is_error), 32'd1);
        repeat (300) @(negedge clk);
        chk("uf_sticky", 32'(is_error), 32'd1);

        // Backpressure on two lefts, slot width switched mid-slot.
        do_reset(1'b0, 1'b0, 1'b0);
        send(1'b1, 32'hABCD0000);
        @(negedge clk);
        chk("bp_ready_low", 32'(bus.i_ready), 32'd0);
        @(posedge clk); #1;
        send(1'b1, 32'h5A5A0000);
        is_32bit = 1'b1;
        wait_words(3);
        chk("bp_w0", rx_words[0], 32'h0000ABCD);
        chk("bp_w1", rx_words[1], 32'h00000000);
        chk("bp_w2", rx_words[2], 32'h5A5A0000);
        chk("bp_ch2", 32'(rx_left[2]), 32'd1);

        // Idle frames after reset.
        do_reset(1'b0, 1'b1, 1'b0);
        rises = 0; prev_sclk = 1'b0; saw_one = 1'b0;
        repeat (512) begin
            @(negedge clk);
            if (sclk && !prev_sclk) rises++;
            prev_sclk = sclk;
            if (sdout) saw_one = 1'b1;
        end
        chk("idle_rises", 32'(rises), 32'd128);
        chk("idle_sdout", 32'(saw_one), 32'd0);
        chk("idle_err", 32'(is_error), 32'd0);

        // Reset in the middle of a left slot (bit 7 of 0xFFFF).
        do_reset(1'b0, 1'b0, 1'b0);
        send(1'b1, 32'hFFFF0000);
        send(1'b0, 32'h00010000);
        send(1'b1, 32'h0F0F0000);
        is_i2s = 1'b1;
        wait_t(94);
        chk("mid_sclk_pre", 32'(sclk), 32'd1);
        chk("mid_sdout_pre", 32'(sdout), 32'd1);
        chk("mid_ready_pre", 32'(bus.i_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_sclk", 32'(sclk), 32'd0);
        chk("mid_lrclk", 32'(lrclk), 32'd0);
        chk("mid_sdout", 32'(sdout), 32'd0);
        chk("mid_ready", 32'(bus.i_ready), 32'd1);
        chk("mid_err", 32'(is_error), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        send(1'b1, 32'hC3C30000);
        repeat (300) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
